// File: rtl/rs_dec_syndrome_bank.sv
// Reed-Solomon decoder syndrome bank over GF(2^8), primitive poly 0x11D, alpha = 0x02.
// Accumulates N_SYND syndromes S_j = r(alpha^j) of an N_BYTES codeword, highest-degree
// symbol first, using Horner's rule: one multiply-by-constant and XOR per byte per syndrome.
// Ports:
//   i_clk          clock, rising edge
//   i_resb         asynchronous active-low reset
//   i_frame_sync   synchronous codeword restart (discards partial codeword)
//   i_data         received symbol
//   i_data_valid   i_data sampled when high
//   o_synd         latched syndromes, S_j at [8j+7:8j]
//   o_synd_valid   one-cycle pulse when o_synd updates
//   o_nonzero      any latched syndrome non-zero
//   o_busy         partial codeword in progress (combinational)
module rs_dec_syndrome_bank #(
    parameter int unsigned N_BYTES = 32,
    parameter int unsigned N_SYND  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_resb,
    input  logic                  i_frame_sync,
    input  logic [7:0]            i_data,
    input  logic                  i_data_valid,
    output logic [8*N_SYND-1:0]   o_synd,
    output logic                  o_synd_valid,
    output logic                  o_nonzero,
    output logic                  o_busy
);

    localparam int unsigned CNT_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned SYND_W = 8 * N_SYND;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

    // Multiply by alpha: shift left, fold x^8 back as x^4+x^3+x^2+1.
    function automatic logic [7:0] mul_alpha(input logic [7:0] x);
        return x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    endfunction

    // Multiply by alpha^p for a constant p: a fixed chain of mul_alpha stages.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] x, input int unsigned p);
        logic [7:0] r;
        r = x;
        for (int unsigned k = 0; k < p; k++) begin
            r = mul_alpha(r);
        end
        return r;
    endfunction

    logic [SYND_W-1:0] acc_q, acc_d, acc_base, horner;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
    logic [SYND_W-1:0] synd_q, synd_d;
    logic              synd_valid_q, synd_valid_d;
    logic              nonzero_q, nonzero_d;

    // Frame sync restarts the codeword before the current byte is folded in.
    assign acc_base = i_frame_sync ? '0 : acc_q;
    assign cnt_base = i_frame_sync ? '0 : cnt_q;

    // One Horner step per syndrome: acc_j * alpha^j ^ d.
    for (genvar j = 0; j < int'(N_SYND); j++) begin : g_horner
        assign horner[8*j +: 8] = mul_alpha_pow(acc_base[8*j +: 8], j) ^ i_data;
    end

    // Next-state: accumulate, or latch results on the last byte of the codeword.
    always_comb begin
        acc_d        = acc_base;
        cnt_d        = cnt_base;
        synd_d       = synd_q;
        nonzero_d    = nonzero_q;
        synd_valid_d = 1'b0;
        if (i_data_valid) begin
            if (cnt_base == LAST_IDX) begin
                synd_d       = horner;
                nonzero_d    = |horner;
                synd_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
            end else begin
                acc_d = horner;
                cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            synd_q       <= '0;
            synd_valid_q <= 1'b0;
            nonzero_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            synd_q       <= synd_d;
            synd_valid_q <= synd_valid_d;
            nonzero_q    <= nonzero_d;
        end
    end

    assign o_synd       = synd_q;
    assign o_synd_valid = synd_valid_q;
    assign o_nonzero    = nonzero_q;
    assign o_busy       = (cnt_q != '0);

endmodule

// File: tb/tb_rs_dec_syndrome_bank.sv
// Directed bench for rs_dec_syndrome_bank: default C1 instance (32 bytes) and a C2
// instance (28 bytes) sharing clock and reset. Expected syndromes come from hand
// constants and a direct polynomial-evaluation GF(2^8) model.
module tb_rs_dec_syndrome_bank;

    logic clk = 1'b0;
    logic resb;
    always #5 clk = ~clk;

    logic        fs1, v1, sv1, nz1, busy1;
    logic [7:0]  d1;
    logic [31:0] synd1;
    logic        fs2, v2, sv2, nz2, busy2;
    logic [7:0]  d2;
    logic [31:0] synd2;

    int tests = 0;
    int fails = 0;
    int pulses1 = 0;
    int pulses2 = 0;

    logic [7:0] cw  [0:31];
    logic [7:0] gen [0:4];

    rs_dec_syndrome_bank dut1 (
        .i_clk(clk), .i_resb(resb), .i_frame_sync(fs1), .i_data(d1), .i_data_valid(v1),
        .o_synd(synd1), .o_synd_valid(sv1), .o_nonzero(nz1), .o_busy(busy1)
    );

    rs_dec_syndrome_bank #(.N_BYTES(28), .N_SYND(4)) dut2 (
        .i_clk(clk), .i_resb(resb), .i_frame_sync(fs2), .i_data(d2), .i_data_valid(v2),
        .o_synd(synd2), .o_synd_valid(sv2), .o_nonzero(nz2), .o_busy(busy2)
    );

    always @(negedge clk) begin
        if (sv1) pulses1++;
        if (sv2) pulses2++;
    end

    // ---------------- GF(2^8) model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    // Direct evaluation S_j = sum cw[k] * alpha^(j*(n-1-k)).
    function automatic logic [31:0] syn_model(input int n);
        logic [31:0] res;
        logic [7:0]  s;
        res = 32'h0;
        for (int j = 0; j < 4; j++) begin
            s = 8'h00;
            for (int k = 0; k < n; k++) s = s ^ gf_mul(cw[k], gf_pow(j * (n - 1 - k)));
            res[8*j +: 8] = s;
        end
        return res;
    endfunction

    // Systematic RS(28,24) encode with generator roots alpha^0..alpha^3.
    task automatic encode_c2();
        logic [7:0] rem [0:3];
        logic [7:0] fb;
        for (int k = 0; k < 4; k++) rem[k] = 8'h00;
        for (int k = 0; k < 24; k++) begin
            cw[k] = 8'($urandom_range(0, 255));
            fb = cw[k] ^ rem[3];
            rem[3] = rem[2] ^ gf_mul(fb, gen[3]);
            rem[2] = rem[1] ^ gf_mul(fb, gen[2]);
            rem[1] = rem[0] ^ gf_mul(fb, gen[1]);
            rem[0] = gf_mul(fb, gen[0]);
        end
        cw[24] = rem[3];
        cw[25] = rem[2];
        cw[26] = rem[1];
        cw[27] = rem[0];
    endtask

    task automatic build_gen();
        logic [7:0] a;
        gen[0] = 8'h01;
        for (int k = 1; k < 5; k++) gen[k] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            a = gf_pow(i);
            for (int k = 4; k > 0; k--) gen[k] = gen[k-1] ^ gf_mul(gen[k], a);
            gen[0] = gf_mul(gen[0], a);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive1(input logic [7:0] d, input logic v, input logic fs);
        d1 = d; v1 = v; fs1 = fs;
        @(posedge clk); #1;
    endtask

    task automatic drive2(input logic [7:0] d, input logic v, input logic fs);
        d2 = d; v2 = v; fs2 = fs;
        @(posedge clk); #1;
    endtask

    task automatic send_cw1();
        for (int k = 0; k < 32; k++) drive1(cw[k], 1'b1, 1'b0);
    endtask

    task automatic clear_cw();
        for (int k = 0; k < 32; k++) cw[k] = 8'h00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resb = 1'b0;
        fs1 = 1'b0; v1 = 1'b0; d1 = 8'h00;
        fs2 = 1'b0; v2 = 1'b0; d2 = 8'h00;
        #12;
        tests++; if (synd1 !== 32'h0) begin fails++; $display("FAIL reset_synd1: got %h expected %h", synd1, 32'h0); end
        tests++; if ({sv1, nz1, busy1} !== 3'b000) begin fails++; $display("FAIL reset_flags1: got %b expected 000", {sv1, nz1, busy1}); end
        tests++; if (synd2 !== 32'h0) begin fails++; $display("FAIL reset_synd2: got %h expected %h", synd2, 32'h0); end
        @(negedge clk) resb = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zeros();
        int p0;
        p0 = pulses1;
        clear_cw();
        for (int k = 0; k < 32; k++) begin
            drive1(8'h00, 1'b1, 1'b0);
            if (k == 0) begin
                tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL zeros_busy: got %b expected 1", busy1); end
            end
        end
        tests++; if (sv1 !== 1'b1) begin fails++; $display("FAIL zeros_valid: got %b expected 1", sv1); end
        tests++; if (synd1 !== 32'h0) begin fails++; $display("FAIL zeros_synd: got %h expected 0", synd1); end
        tests++; if ({nz1, busy1} !== 2'b00) begin fails++; $display("FAIL zeros_nz_busy: got %b expected 00", {nz1, busy1}); end
        drive1(8'h00, 1'b0, 1'b0);
        tests++; if (sv1 !== 1'b0) begin fails++; $display("FAIL zeros_pulse_width: got %b expected 0", sv1); end
        tests++; if (pulses1 - p0 !== 1) begin fails++; $display("FAIL zeros_pulse_count: got %0d expected 1", pulses1 - p0); end
    endtask

    task automatic test_single_one();
        clear_cw();
        cw[31] = 8'h01;
        send_cw1();
        tests++; if (synd1 !== 32'h01010101) begin fails++; $display("FAIL last_one_synd: got %h expected %h", synd1, 32'h01010101); end
        tests++; if (nz1 !== 1'b1) begin fails++; $display("FAIL last_one_nz: got %b expected 1", nz1); end
        clear_cw();
        cw[30] = 8'h01;
        send_cw1();
        tests++; if (synd1 !== 32'h08040201) begin fails++; $display("FAIL b30_one_synd: got %h expected %h", synd1, 32'h08040201); end
        tests++; if (synd1 !== syn_model(32)) begin fails++; $display("FAIL b30_one_model: got %h expected %h", synd1, syn_model(32)); end
        drive1(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_frame_sync();
        int p0;
        p0 = pulses1;
        for (int k = 0; k < 10; k++) drive1(8'(165 + k), 1'b1, 1'b0);
        tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL fsync_busy_before: got %b expected 1", busy1); end
        drive1(8'h00, 1'b0, 1'b1);
        tests++; if ({busy1, sv1} !== 2'b00) begin fails++; $display("FAIL fsync_clear: got %b expected 00", {busy1, sv1}); end
        tests++; if (synd1 !== 32'h08040201) begin fails++; $display("FAIL fsync_hold: got %h expected %h", synd1, 32'h08040201); end
        for (int k = 0; k < 31; k++) drive1(8'h00, 1'b1, 1'b0);
        tests++; if (synd1 !== 32'h08040201 || sv1 !== 1'b0) begin fails++; $display("FAIL fsync_hold_late: got %h/%b expected %h/0", synd1, sv1, 32'h08040201); end
        drive1(8'h00, 1'b1, 1'b0);
        tests++; if (sv1 !== 1'b1 || synd1 !== 32'h0 || nz1 !== 1'b0) begin fails++; $display("FAIL fsync_result: got %b/%h/%b expected 1/0/0", sv1, synd1, nz1); end
        drive1(8'h00, 1'b0, 1'b0);
        tests++; if (pulses1 - p0 !== 1) begin fails++; $display("FAIL fsync_pulse_count: got %0d expected 1", pulses1 - p0); end
    endtask

    task automatic test_fs_with_byte();
        for (int k = 0; k < 5; k++) drive1(8'h33, 1'b1, 1'b0);
        drive1(8'h01, 1'b1, 1'b1);
        tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL fs_byte_busy: got %b expected 1", busy1); end
        for (int k = 0; k < 31; k++) drive1(8'h00, 1'b1, 1'b0);
        clear_cw();
        cw[0] = 8'h01;
        tests++; if (sv1 !== 1'b1 || synd1 !== syn_model(32)) begin fails++; $display("FAIL fs_byte_synd: got %b/%h expected 1/%h", sv1, synd1, syn_model(32)); end
        tests++; if (synd1[7:0] !== 8'h01 || nz1 !== 1'b1) begin fails++; $display("FAIL fs_byte_s0: got %h/%b expected 01/1", synd1[7:0], nz1); end
        drive1(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_c2();
        int p0;
        logic [31:0] exp_s;
        p0 = pulses2;
        build_gen();
        for (int c = 0; c < 3; c++) begin
            encode_c2();
            for (int k = 0; k < 28; k++) drive2(cw[k], 1'b1, 1'b0);
            tests++; if (sv2 !== 1'b1 || synd2 !== 32'h0 || nz2 !== 1'b0) begin fails++; $display("FAIL c2_b2b_%0d: got %b/%h/%b expected 1/0/0", c, sv2, synd2, nz2); end
        end
        encode_c2();
        for (int k = 0; k < 28; k++) begin
            drive2(cw[k], 1'b1, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive2(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end
        tests++; if (synd2 !== 32'h0 || nz2 !== 1'b0) begin fails++; $display("FAIL c2_gapped: got %h/%b expected 0/0", synd2, nz2); end
        drive2(8'h00, 1'b0, 1'b0);
        encode_c2();
        cw[7] = cw[7] ^ 8'h5A;
        exp_s = syn_model(28);
        for (int k = 0; k < 28; k++) drive2(cw[k], 1'b1, 1'b0);
        tests++; if (sv2 !== 1'b1 || nz2 !== 1'b1) begin fails++; $display("FAIL c2_err_flag: got %b/%b expected 1/1", sv2, nz2); end
        tests++; if (synd2 !== exp_s || exp_s == 32'h0) begin fails++; $display("FAIL c2_err_synd: got %h expected %h", synd2, exp_s); end
        drive2(8'h00, 1'b0, 1'b0);
        tests++; if (pulses2 - p0 !== 5) begin fails++; $display("FAIL c2_pulse_count: got %0d expected 5", pulses2 - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int k = 0; k < 15; k++) drive1(8'h77, 1'b1, 1'b0);
        #2 resb = 1'b0;
        #1;
        tests++; if (synd1 !== 32'h0) begin fails++; $display("FAIL rstmid_synd: got %h expected 0", synd1); end
        tests++; if ({sv1, nz1, busy1} !== 3'b000) begin fails++; $display("FAIL rstmid_flags: got %b expected 000", {sv1, nz1, busy1}); end
        v1 = 1'b0;
        @(negedge clk) resb = 1'b1;
        @(posedge clk); #1;
        p0 = pulses1;
        clear_cw();
        cw[30] = 8'h01;
        send_cw1();
        tests++; if (sv1 !== 1'b1 || synd1 !== 32'h08040201) begin fails++; $display("FAIL rstmid_next: got %b/%h expected 1/%h", sv1, synd1, 32'h08040201); end
        drive1(8'h00, 1'b0, 1'b0);
        tests++; if (pulses1 - p0 !== 1) begin fails++; $display("FAIL rstmid_pulse_count: got %0d expected 1", pulses1 - p0); end
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_single_one();
        test_frame_sync();
        test_fs_with_byte();
        test_c2();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
